// File: rtl/space_invaders_pkg.sv
// Shared types and geometry for the space-invaders video pipeline.
package space_invaders_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FLYING    = 2'd1,
    ST_EXPLODING = 2'd2,
    ST_RETIRE    = 2'd3
  } missile_state_e;

endpackage

// File: rtl/player_cannon_ctrl_if.sv
// Input pulses and player state outputs of the player cannon controller.
interface player_cannon_ctrl_if;
  import space_invaders_pkg::*;

  logic   frame_tick;
  logic   left_pulse;
  logic   right_pulse;
  logic   fire_pulse;
  logic   missile_hit;
  coord_t cannon_x;
  coord_t missile_x;
  coord_t missile_y;
  logic   missile_active;
  logic   missile_exploding;
  logic   shot_fired;

  modport master (
    output frame_tick, left_pulse, right_pulse, fire_pulse, missile_hit,
    input  cannon_x, missile_x, missile_y, missile_active, missile_exploding, shot_fired
  );

  modport slave (
    input  frame_tick, left_pulse, right_pulse, fire_pulse, missile_hit,
    output cannon_x, missile_x, missile_y, missile_active, missile_exploding, shot_fired
  );

endinterface

// File: rtl/player_missile.sv
// Single player missile: launch, flight, explosion and one-cycle retirement.
module player_missile
  import space_invaders_pkg::*;
#(
  parameter int CANNON_W        = 32,
  parameter int MISSILE_Y_START = 540,
  parameter int MISSILE_Y_TOP   = 40,
  parameter int MISSILE_STEP    = 6,
  parameter int EXPLODE_FRAMES  = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  coord_t i_cannon_x,
  input  logic   i_fire,
  input  logic   i_hit,
  input  logic   i_frame_tick,
  output coord_t o_missile_x,
  output coord_t o_missile_y,
  output logic   o_missile_active,
  output logic   o_missile_exploding,
  output logic   o_shot_fired
);

  localparam int CNT_W = $clog2(EXPLODE_FRAMES + 1);

  localparam coord_t            HALF_W    = coord_t'(CANNON_W / 2);
  localparam coord_t            Y_START   = coord_t'(MISSILE_Y_START);
  localparam coord_t            Y_RETIRE  = coord_t'(MISSILE_Y_TOP + MISSILE_STEP);
  localparam coord_t            Y_STEP    = coord_t'(MISSILE_STEP);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(EXPLODE_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  missile_state_e   r_state, w_state_next;
  coord_t           r_x, r_y, w_x_next, w_y_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_shot, w_shot_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous and overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_shot  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_cnt   <= w_cnt_next;
      r_shot  <= w_shot_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_cnt_next   = r_cnt;
    w_shot_next  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_fire) begin
          w_state_next = ST_FLYING;
          w_x_next     = i_cannon_x + HALF_W;
          w_y_next     = Y_START;
          w_shot_next  = 1'b1;
        end
      end
      ST_FLYING: begin
        // A hit outranks a coincident frame tick, so the explosion sits where the hit was seen.
        if (i_hit) begin
          w_state_next = ST_EXPLODING;
          w_cnt_next   = CNT_LOAD;
        end else if (i_frame_tick) begin
          if (r_y < Y_RETIRE) w_state_next = ST_RETIRE;
          else                w_y_next     = r_y - Y_STEP;
        end
      end
      ST_EXPLODING: begin
        if (i_frame_tick) begin
          if (r_cnt <= CNT_ONE) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CNT_ONE;
          end
        end
      end
      ST_RETIRE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign o_missile_x         = r_x;
  assign o_missile_y         = r_y;
  assign o_missile_active    = (r_state == ST_FLYING);
  assign o_missile_exploding = (r_state == ST_EXPLODING);
  assign o_shot_fired        = r_shot;

endmodule

// File: rtl/player_cannon_ctrl.sv
// Player cannon position with edge clamping, plus the player missile sub-block.
module player_cannon_ctrl
  import space_invaders_pkg::coord_t;
#(
  parameter int SCREEN_W        = space_invaders_pkg::SCREEN_W,
  parameter int CANNON_W        = 32,
  parameter int CANNON_X_INIT   = 384,
  parameter int MOVE_STEP       = 8,
  parameter int MISSILE_Y_START = 540,
  parameter int MISSILE_Y_TOP   = 40,
  parameter int MISSILE_STEP    = 6,
  parameter int EXPLODE_FRAMES  = 8
) (
  input logic                 clk_36MHz,
  input logic                 reset,
  player_cannon_ctrl_if.slave bus
);

  localparam coord_t X_MAX  = coord_t'(SCREEN_W - CANNON_W);
  localparam coord_t X_INIT = coord_t'(CANNON_X_INIT);
  localparam coord_t STEP   = coord_t'(MOVE_STEP);

  coord_t r_cannon_x, w_cannon_next;

  // Opposite pulses in one cycle cancel; each bound compare happens before the add/subtract so nothing wraps.
  always_comb begin
    w_cannon_next = r_cannon_x;
    if (bus.left_pulse && !bus.right_pulse) begin
      w_cannon_next = (r_cannon_x < STEP) ? '0 : r_cannon_x - STEP;
    end else if (bus.right_pulse && !bus.left_pulse) begin
      w_cannon_next = (r_cannon_x > X_MAX - STEP) ? X_MAX : r_cannon_x + STEP;
    end
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) r_cannon_x <= X_INIT;
    else       r_cannon_x <= w_cannon_next;
  end

  assign bus.cannon_x = r_cannon_x;

  player_missile #(
    .CANNON_W        (CANNON_W),
    .MISSILE_Y_START (MISSILE_Y_START),
    .MISSILE_Y_TOP   (MISSILE_Y_TOP),
    .MISSILE_STEP    (MISSILE_STEP),
    .EXPLODE_FRAMES  (EXPLODE_FRAMES)
  ) u_missile (
    .clk                 (clk_36MHz),
    .reset               (reset),
    .i_cannon_x          (r_cannon_x),
    .i_fire              (bus.fire_pulse),
    .i_hit               (bus.missile_hit),
    .i_frame_tick        (bus.frame_tick),
    .o_missile_x         (bus.missile_x),
    .o_missile_y         (bus.missile_y),
    .o_missile_active    (bus.missile_active),
    .o_missile_exploding (bus.missile_exploding),
    .o_shot_fired        (bus.shot_fired)
  );

endmodule

// File: tb/tb_player_cannon_ctrl.sv
// Directed scoreboard bench for player_cannon_ctrl: clamping, flight, hit, retire and reset.
module tb_player_cannon_ctrl;

  typedef struct {
    string    tag;
    int       cx;
    int       mx;
    int       my;
    bit       act;
    bit       expl;
    bit       shot;
    bit       pos;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_err    = 0;
  int   n_checks = 0;
  exp_t exp_q[$];

  player_cannon_ctrl_if bus_if ();

  player_cannon_ctrl dut (
    .clk_36MHz (clk),
    .reset     (reset),
    .bus       (bus_if)
  );

  always #14 clk = ~clk;

  function automatic exp_t e(input string tag, input int cx, input int mx, input int my,
                             input bit act, input bit expl, input bit shot, input bit pos);
    exp_t r;
    r.tag = tag; r.cx = cx; r.mx = mx; r.my = my;
    r.act = act; r.expl = expl; r.shot = shot; r.pos = pos;
    return r;
  endfunction

  task automatic chk(input string tag, input string field, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s.%s: observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic compare_front();
    exp_t x;
    x = exp_q.pop_front();
    chk(x.tag, "cannon_x", int'(bus_if.cannon_x), x.cx);
    chk(x.tag, "active", int'(bus_if.missile_active), int'(x.act));
    chk(x.tag, "exploding", int'(bus_if.missile_exploding), int'(x.expl));
    chk(x.tag, "shot_fired", int'(bus_if.shot_fired), int'(x.shot));
    if (x.pos) begin
      chk(x.tag, "missile_x", int'(bus_if.missile_x), x.mx);
      chk(x.tag, "missile_y", int'(bus_if.missile_y), x.my);
    end
  endtask

  task automatic cycle(input logic rst, input logic l, input logic r, input logic f,
                       input logic t, input logic h, input exp_t ex);
    @(negedge clk);
    reset                  = rst;
    bus_if.left_pulse      = l;
    bus_if.right_pulse     = r;
    bus_if.fire_pulse      = f;
    bus_if.frame_tick      = t;
    bus_if.missile_hit     = h;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    int x;
    bus_if.left_pulse  = 1'b0;
    bus_if.right_pulse = 1'b0;
    bus_if.fire_pulse  = 1'b0;
    bus_if.frame_tick  = 1'b0;
    bus_if.missile_hit = 1'b0;

    // reset
    cycle(1, 0, 0, 0, 0, 0, e("rst1", 384, 0, 0, 0, 0, 0, 1));
    cycle(1, 0, 0, 0, 0, 0, e("rst2", 384, 0, 0, 0, 0, 0, 1));
    cycle(0, 0, 0, 0, 0, 0, e("rst_rel", 384, 0, 0, 0, 0, 0, 1));

    // full flight to retirement
    cycle(0, 0, 0, 1, 0, 0, e("launch", 384, 400, 540, 1, 0, 1, 1));
    cycle(0, 0, 0, 0, 0, 0, e("launch_p1", 384, 400, 540, 1, 0, 0, 1));
    cycle(0, 0, 0, 1, 0, 0, e("fire_fly", 384, 400, 540, 1, 0, 0, 1));
    for (int k = 1; k <= 83; k++)
      cycle(0, 0, 0, 0, 1, 0, e($sformatf("fly%0d", k), 384, 400, 540 - 6 * k, 1, 0, 0, 1));
    cycle(0, 0, 0, 0, 1, 0, e("retire", 384, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 1, 0, 0, e("fire_retire", 384, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, 0, e("idle_after", 384, 0, 0, 0, 0, 0, 0));

    // launch with same-cycle move, fly to y=300, hit coinciding with a tick
    cycle(0, 1, 0, 1, 0, 0, e("launch_move", 376, 400, 540, 1, 0, 1, 1));
    for (int k = 1; k <= 40; k++)
      cycle(0, 0, 0, 0, 1, 0, e($sformatf("fly_b%0d", k), 376, 400, 540 - 6 * k, 1, 0, 0, 1));
    cycle(0, 0, 0, 0, 1, 1, e("hit", 376, 400, 300, 0, 1, 0, 1));
    cycle(0, 0, 0, 1, 0, 0, e("fire_expl", 376, 400, 300, 0, 1, 0, 1));
    for (int k = 1; k <= 7; k++)
      cycle(0, 0, 0, 0, 1, 0, e($sformatf("expl%0d", k), 376, 400, 300, 0, 1, 0, 1));
    cycle(0, 0, 0, 0, 1, 0, e("expl_done", 376, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, 1, e("hit_idle", 376, 0, 0, 0, 0, 0, 0));
    cycle(0, 0, 0, 1, 0, 0, e("relaunch", 376, 392, 540, 1, 0, 1, 1));

    // reset mid-flight
    cycle(0, 0, 0, 0, 1, 0, e("fly_c", 376, 392, 534, 1, 0, 0, 1));
    cycle(1, 0, 0, 0, 0, 0, e("rst_fly", 384, 0, 0, 0, 0, 0, 1));
    cycle(0, 0, 0, 0, 0, 0, e("rst_fly_rel", 384, 0, 0, 0, 0, 0, 1));

    // left clamp
    for (int i = 0; i < 60; i++) begin
      x = 384 - 8 * (i + 1);
      if (x < 0) x = 0;
      cycle(0, 1, 0, 0, 0, 0, e($sformatf("left%0d", i + 1), x, 0, 0, 0, 0, 0, 1));
    end
    cycle(0, 1, 1, 0, 0, 0, e("lr_zero", 0, 0, 0, 0, 0, 0, 1));

    // walk right to 760, then clamp at 768
    for (int i = 0; i < 95; i++)
      cycle(0, 0, 1, 0, 0, 0, e($sformatf("right%0d", i + 1), 8 * (i + 1), 0, 0, 0, 0, 0, 1));
    cycle(0, 1, 1, 0, 0, 0, e("lr_mid", 760, 0, 0, 0, 0, 0, 1));
    cycle(0, 0, 1, 0, 0, 0, e("right_clamp1", 768, 0, 0, 0, 0, 0, 1));
    cycle(0, 0, 1, 0, 0, 0, e("right_clamp2", 768, 0, 0, 0, 0, 0, 1));
    cycle(0, 0, 1, 0, 0, 0, e("right_clamp3", 768, 0, 0, 0, 0, 0, 1));
    cycle(0, 1, 1, 0, 0, 0, e("lr_max", 768, 0, 0, 0, 0, 0, 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
